// File: rtl/score_arbiter_if.sv
// Bundles the round handshake, result and statistics signals of score_arbiter.
// master drives the round (start/scores/ack); slave is the arbiter itself.
interface score_arbiter_if;
  logic       start;
  logic       abort;
  logic       score_valid;
  logic [6:0] score_in;
  logic       ack;
  logic       score_ready;
  logic       busy;
  logic       done;
  logic [3:0] winner;
  logic       tie;
  logic [1:0] slot;
  logic [7:0] round_cnt;
  logic [3:0] wins_a;
  logic [3:0] wins_b;
  logic [3:0] wins_c;
  logic [3:0] wins_d;
  logic [1:0] fsmState;

  // Handshake: a score moves on a rising edge where score_valid && score_ready;
  // the master may change score_in freely while either is low, and abort wins over a transfer.
  modport master (
    output start, abort, score_valid, score_in, ack,
    input  score_ready, busy, done, winner, tie, slot, round_cnt,
    input  wins_a, wins_b, wins_c, wins_d, fsmState
  );

  modport slave (
    input  start, abort, score_valid, score_in, ack,
    output score_ready, busy, done, winner, tie, slot, round_cnt,
    output wins_a, wins_b, wins_c, wins_d, fsmState
  );
endinterface

// File: rtl/score_arbiter.sv
// Four-player score arbiter: loads scores A..D, picks every slot equal to the
// round maximum, and keeps saturating per-player win counters plus a round count.
module score_arbiter (
  input  logic            clk,
  input  logic            rst_n,
  score_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPARE = 2'd2,
    RESULT  = 2'd3
  } state_t;

  state_t     state;
  state_t     nextState;
  logic [1:0] slotQ;
  logic [6:0] scores [4];
  logic [3:0] winnerQ;
  logic       tieQ;
  logic [7:0] roundCnt;
  logic [3:0] winsA, winsB, winsC, winsD;

  logic [6:0] scoreClamped;
  logic [6:0] maxScore;
  logic [3:0] hitMask;
  logic       multiHit;
  logic       transfer;

  function automatic logic [3:0] satInc(input logic [3:0] v, input logic hit);
    return (hit && (v != 4'd15)) ? v + 4'd1 : v;
  endfunction

  assign scoreClamped = (bus.score_in > 7'd100) ? 7'd100 : bus.score_in;
  assign transfer     = (state == LOAD) && bus.score_valid && !bus.abort;

  // A zero maximum means nobody scored, so the mask is forced empty.
  always_comb begin
    maxScore = scores[0];
    for (int i = 1; i < 4; i++) begin
      if (scores[i] > maxScore) maxScore = scores[i];
    end
    hitMask = {scores[0] == maxScore, scores[1] == maxScore,
               scores[2] == maxScore, scores[3] == maxScore} & {4{maxScore != 7'd0}};
    multiHit = (hitMask & (hitMask - 4'd1)) != 4'd0;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (bus.start) nextState = LOAD;
      LOAD: begin
        if (bus.abort)                          nextState = IDLE;
        else if (bus.score_valid && slotQ == 2'd3) nextState = COMPARE;
      end
      COMPARE: nextState = RESULT;
      RESULT:  if (bus.ack) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slotQ    <= 2'd0;
      winnerQ  <= 4'd0;
      tieQ     <= 1'b0;
      roundCnt <= 8'd0;
      winsA    <= 4'd0;
      winsB    <= 4'd0;
      winsC    <= 4'd0;
      winsD    <= 4'd0;
      for (int i = 0; i < 4; i++) scores[i] <= 7'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            slotQ <= 2'd0;
            for (int i = 0; i < 4; i++) scores[i] <= 7'd0;
          end
        end
        LOAD: begin
          if (bus.abort) begin
            slotQ <= 2'd0;
            for (int i = 0; i < 4; i++) scores[i] <= 7'd0;
          end else if (transfer) begin
            scores[slotQ] <= scoreClamped;
            slotQ         <= slotQ + 2'd1;
          end
        end
        COMPARE: begin
          winnerQ  <= hitMask;
          tieQ     <= multiHit;
          winsA    <= satInc(winsA, hitMask[3]);
          winsB    <= satInc(winsB, hitMask[2]);
          winsC    <= satInc(winsC, hitMask[1]);
          winsD    <= satInc(winsD, hitMask[0]);
          roundCnt <= roundCnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.score_ready = (state == LOAD);
  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == RESULT);
  assign bus.winner      = winnerQ;
  assign bus.tie         = tieQ;
  assign bus.slot        = slotQ;
  assign bus.round_cnt   = roundCnt;
  assign bus.wins_a      = winsA;
  assign bus.wins_b      = winsB;
  assign bus.wins_c      = winsC;
  assign bus.wins_d      = winsD;
  assign bus.fsmState    = state;

endmodule

// File: tb/tb_score_arbiter.sv
// Randomized and directed rounds against a behavioural score model; results are
// queued at issue time and compared by a monitor whenever done rises.
module tb_score_arbiter;
  localparam int W = 29;

  logic clk;
  logic rst_n;
  score_arbiter_if bus();

  score_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  int         m_wins[4];
  int         m_round;
  logic [3:0] m_winner;
  logic       m_tie;

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model
  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_wins[i] = 0;
    m_round  = 0;
    m_winner = 4'd0;
    m_tie    = 1'b0;
  endtask

  task automatic model_round(input logic [6:0] s[4]);
    int c[4];
    int mx;
    int n;
    mx = 0;
    n  = 0;
    for (int i = 0; i < 4; i++) begin
      c[i] = (s[i] > 100) ? 100 : int'(s[i]);
      if (c[i] > mx) mx = c[i];
    end
    m_winner = 4'd0;
    if (mx > 0) begin
      for (int i = 0; i < 4; i++) begin
        if (c[i] == mx) begin
          m_winner[3-i] = 1'b1;
          n++;
          if (m_wins[i] < 15) m_wins[i]++;
        end
      end
    end
    m_tie   = (n > 1);
    m_round = (m_round + 1) % 256;
  endtask

  function automatic logic [W-1:0] pack_exp();
    logic [3:0] wa, wb, wc, wd;
    logic [7:0] rc;
    wa = m_wins[0][3:0];
    wb = m_wins[1][3:0];
    wc = m_wins[2][3:0];
    wd = m_wins[3][3:0];
    rc = m_round[7:0];
    return {m_winner, m_tie, wa, wb, wc, wd, rc};
  endfunction

  task automatic check_held(input string tag);
    check({tag, "_winner"}, bus.winner, m_winner);
    check({tag, "_tie"}, bus.tie, m_tie);
    check({tag, "_wins_a"}, bus.wins_a, m_wins[0]);
    check({tag, "_wins_b"}, bus.wins_b, m_wins[1]);
    check({tag, "_wins_c"}, bus.wins_c, m_wins[2]);
    check({tag, "_wins_d"}, bus.wins_d, m_wins[3]);
    check({tag, "_round_cnt"}, bus.round_cnt, m_round);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, bus.score_ready, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_slot"}, bus.slot, 0);
    check({tag, "_state"}, bus.fsmState, 0);
    check_held(tag);
  endtask

  // Monitor: one expected result per rising edge of done
  initial begin
    logic         prev_done;
    logic [W-1:0] e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1 && prev_done !== 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: done rose with empty queue, winner %0h", bus.winner);
        end else begin
          e = exp_q.pop_front();
          check("res_winner", bus.winner, e[28:25]);
          check("res_tie", bus.tie, e[24]);
          check("res_wins_a", bus.wins_a, e[23:20]);
          check("res_wins_b", bus.wins_b, e[19:16]);
          check("res_wins_c", bus.wins_c, e[15:12]);
          check("res_wins_d", bus.wins_d, e[11:8]);
          check("res_round_cnt", bus.round_cnt, e[7:0]);
        end
      end
      prev_done = bus.done;
    end
  end

  // Driver
  task automatic run_round(input logic [6:0] s[4], input int stall_at, input int stall_len,
                           input int abort_at, input int ack_hold, input logic start_with_ack);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("ready_in_load", bus.score_ready, 1);
    for (int i = 0; i < 4; i++) begin
      if (i == stall_at) begin
        for (int k = 0; k < stall_len; k++) begin
          bus.score_valid = 1'b0;
          bus.score_in    = 7'($urandom_range(0, 127));
          @(negedge clk);
          check("stall_slot", bus.slot, i);
        end
      end
      if (i == abort_at) begin
        bus.abort       = 1'b1;
        bus.score_valid = 1'($urandom_range(0, 1));
        bus.score_in    = s[i];
        @(negedge clk);
        bus.abort       = 1'b0;
        bus.score_valid = 1'b0;
        check("abort_idle", bus.busy, 0);
        check("abort_slot", bus.slot, 0);
        check_held("abort");
        return;
      end
      bus.score_valid = 1'b1;
      bus.score_in    = s[i];
      @(negedge clk);
    end
    bus.score_valid = 1'b0;
    check("done_not_early", bus.done, 0);
    model_round(s);
    exp_q.push_back(pack_exp());
    @(negedge clk);
    check("done_latency", bus.done, 1);
    for (int k = 0; k < ack_hold; k++) begin
      @(negedge clk);
      check("hold_done", bus.done, 1);
      check("hold_winner", bus.winner, m_winner);
      check("hold_tie", bus.tie, m_tie);
    end
    bus.ack   = 1'b1;
    bus.start = start_with_ack;
    @(negedge clk);
    bus.ack   = 1'b0;
    bus.start = 1'b0;
    check("ack_idle", bus.busy, 0);
    @(negedge clk);
    check("stay_idle", bus.busy, 0);
  endtask

  function automatic logic [6:0] rand_score();
    case ($urandom_range(0, 3))
      0:       return 7'd0;
      1:       return 7'd100;
      2:       return 7'd50;
      default: return 7'($urandom_range(0, 127));
    endcase
  endfunction

  initial begin
    logic [6:0] sc[4];
    int         ab;

    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.score_valid = 1'b0;
    bus.score_in    = 7'd0;
    bus.ack         = 1'b0;
    model_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Valid in IDLE is not a transfer and the block waits for start
    bus.score_valid = 1'b1;
    bus.score_in    = 7'd77;
    repeat (3) begin
      @(negedge clk);
      check("idle_wait_busy", bus.busy, 0);
      check("idle_wait_slot", bus.slot, 0);
    end
    bus.score_valid = 1'b0;

    sc = '{7'd100, 7'd0, 7'd0, 7'd0};
    run_round(sc, -1, 0, -1, 0, 1'b0);
    check("single_wins_a", bus.wins_a, 1);
    sc = '{7'd100, 7'd100, 7'd100, 7'd25};
    run_round(sc, -1, 0, -1, 1, 1'b0);
    sc = '{7'd0, 7'd0, 7'd0, 7'd0};
    run_round(sc, -1, 0, -1, 0, 1'b0);
    sc = '{7'd0, 7'd2, 7'd120, 7'd100};
    run_round(sc, -1, 0, -1, 2, 1'b0);
    sc = '{7'd10, 7'd90, 7'd30, 7'd90};
    run_round(sc, 1, 3, 2, 0, 1'b0);
    run_round(sc, 2, 3, -1, 10, 1'b1);

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 4; i++) sc[i] = rand_score();
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_round(sc, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), ab,
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    sc = '{7'd25, 7'd50, 7'd50, 7'd0};
    for (int r = 0; r < 17; r++) run_round(sc, -1, 0, -1, 0, 1'b0);
    check("sat_wins_b", bus.wins_b, 15);
    check("sat_wins_c", bus.wins_c, 15);

    // Reset pulse in the middle of a load
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start       = 1'b0;
    bus.score_valid = 1'b1;
    bus.score_in    = 7'd60;
    @(negedge clk);
    @(negedge clk);
    bus.score_valid = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_reset_outputs("midload_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_idle", bus.busy, 0);

    sc = '{7'd10, 7'd20, 7'd30, 7'd40};
    run_round(sc, -1, 0, -1, 0, 1'b0);
    check("post_reset_wins_d", bus.wins_d, 1);

    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_arbiter.md
SCORE_ARBITER -- requirements
Module: score_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  in  1  system clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 start  in  1  begin a round; sampled only in IDLE.
REQ-005 abort  in  1  cancel a round; honoured only in LOAD.
REQ-006 score_valid  in  1  score_in holds a valid score.
REQ-007 score_in  in  7  score of the current slot, in order A, B, C, D.
REQ-008 ack  in  1  consumer has taken the result; honoured only in RESULT.
REQ-009 score_ready  out  1  high only in LOAD.
REQ-010 busy  out  1  high in LOAD, COMPARE and RESULT.
REQ-011 done  out  1  high only in RESULT.
REQ-012 winner  out  4  bit3=A, bit2=B, bit1=C, bit0=D; set for every slot equal to the round maximum.
REQ-013 tie  out  1  more than one winner bit is set.
REQ-014 slot  out  2  index of the next slot to load (0=A .. 3=D).
REQ-015 round_cnt  out  8  number of completed rounds.
REQ-016 wins_a, wins_b, wins_c, wins_d  out  4 each  accumulated wins per player.

Function
REQ-017 The FSM SHALL have four states: IDLE, LOAD, COMPARE and RESULT.
REQ-018 IDLE with start=1 SHALL go to LOAD with slot=0 on the next edge.
REQ-019 In LOAD, a transfer SHALL occur on any edge with score_valid=1 and score_ready=1.
REQ-020 Each transfer SHALL store score_in in register[slot], then increment slot.
REQ-021 The transfer at slot=3 SHALL move the FSM to COMPARE.
REQ-022 A score_in value above 100 SHALL be stored as 100 (clamp); values 0-100 SHALL be stored unchanged.
REQ-023 COMPARE SHALL last exactly one cycle.
REQ-024 COMPARE SHALL find the maximum M of the four stored scores and register winner, tie and the win counters.
REQ-025 COMPARE SHALL then move to RESULT.
REQ-026 done SHALL rise on the second rising edge after the edge that accepts slot D.
REQ-027 If M=0, winner SHALL be 4'b0000, tie SHALL be 0 and no counter SHALL change (no-winner round).
REQ-028 Each set winner bit SHALL increment its wins_x counter by 1; every counter SHALL saturate at 15.
REQ-029 Every round that reaches RESULT SHALL increment round_cnt, including no-winner rounds; round_cnt SHALL wrap from 255 to 0.
REQ-030 winner and tie SHALL hold stable from RESULT entry until the next COMPARE.
REQ-031 RESULT with ack=1 SHALL return to IDLE on the next edge.
REQ-032 RESULT with ack=0 SHALL remain in RESULT indefinitely.
REQ-033 start asserted outside IDLE SHALL be ignored.
REQ-034 start and ack together in RESULT SHALL act as ack only; a new round needs start in IDLE.
REQ-035 abort in LOAD SHALL return to IDLE on the next edge and discard partial scores; winner, tie and all counters SHALL be unchanged.
REQ-036 abort and a valid transfer on the same edge SHALL give priority to abort, and the transfer SHALL be discarded.
REQ-037 score_valid while score_ready=0 SHALL be ignored, and the score SHALL not be latched.

Reset
REQ-038 rst_n=0 SHALL immediately force state IDLE and slot=0.
REQ-039 rst_n=0 SHALL immediately force score_ready, busy, done, tie=0, winner=4'b0000 and round_cnt=0.
REQ-040 rst_n=0 SHALL immediately force all wins_x=0 and clear all score registers to 0.
REQ-041 Reset asserted mid-round SHALL discard the round with no counter update.
REQ-042 After rst_n deasserts, the block SHALL remain in IDLE until start=1.

Verification
REQ-043 Single winner: load 100,0,0,0 -> winner=1000, tie=0, wins_a=1, round_cnt=1, done 2 edges after the slot-D transfer.
REQ-044 Three-way tie: load 100,100,100,25 -> winner=1110, tie=1; wins_a, wins_b and wins_c each +1; wins_d unchanged.
REQ-045 All zero, then clamp: load 0,0,0,0 -> winner=0000, tie=0, round_cnt+1; then load 0,2,120,100 -> C stored as 100, winner=0011, tie=1.
REQ-046 Handshake: stall score_valid 3 cycles mid-load, then abort at slot=2 -> IDLE, counters unchanged; hold ack=0 10 cycles in RESULT -> done and winner stable.
REQ-047 Saturation and reset: 17 rounds of 25,50,50,0 -> wins_b=wins_c=15; then pulse rst_n low in LOAD -> all outputs at reset values immediately.
